fetch_dispatch_queue: RTL and testbench
=======================================

# fetch_dispatch_queue

Circular instruction buffer between fetch and `dispatch_stage`: accepts up to three `IF_ID_PACKET`s per cycle from fetch, holds them in program order, and presents the three oldest to dispatch in dispatch's slot order (slot 2 oldest). Dequeue count follows dispatch's per-slot stall mask and predicted-taken truncation, so dispatch and queue always agree on which packets left. Squash empties the queue.

## Interface
- `DEPTH`, 8, entry count; power of two, ≥ 4.
- `PTR_W`, `$clog2(DEPTH)`, head/tail pointer width.
- `CNT_W`, `$clog2(DEPTH+1)`, occupancy counter width.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `squash`  in  1  mispredict/exception flush from retire.
- `fq_in_pkts`  in  `IF_ID_PACKET [2:0]`  fetch packets; slot 2 oldest; per-slot `.valid`.
- `fq_in_ready`  out  1  queue accepts this cycle's fetch group.
- `dispatch_stall_mask`  in  3  per-slot stall from dispatch (same meaning as dispatch's input).
- `fq_out_pkts`  out  `IF_ID_PACKET [2:0]`  to dispatch; slot 2 = head, 1 = head+1, 0 = head+2.
- `fq_deq_cnt`  out  2  packets removed at next edge (0–3).
- `fq_count`  out  `CNT_W`  current occupancy.

## Operation
- State: `DEPTH` × `IF_ID_PACKET` storage, `head`, `tail` (`PTR_W`), `count` (`CNT_W`).
- `fq_in_ready = (DEPTH - count) >= 3`, from registered `count` only (no dequeue credit).
- Enqueue when `fq_in_ready && !squash`: valid input slots compacted in order 2,1,0 into `tail`, `tail+1`, …; `enq_n` = number of valid input slots. Invalid slots are skipped and never written. Fetch must hold its group when `fq_in_ready=0`; the queue drops nothing it has accepted.
- Output slot k (k=2,1,0, offset j=2-k) valid iff `j < count` and `!squash`; contents = `mem[head+j]`, `.valid` forced 0 otherwise.
- Dequeue: scan slot 2, 1, 0; a slot is consumed iff its output is valid, its `dispatch_stall_mask` bit is 0, every older slot was consumed, and no older slot has `bp_pred_taken=1`. The first taken slot itself is consumed; younger slots stay. `fq_deq_cnt` = consumed count.
- Packets behind a taken branch that remain in the queue are wrong-path; they are removed by the ensuing redirect `squash`, never dispatched in the same cycle.
- Next state (no squash): `head += fq_deq_cnt`, `tail += enq_n` (accepted only), `count += enq_n - fq_deq_cnt`. Pointers wrap modulo `DEPTH` by natural `PTR_W` overflow.
- `squash`: `head=tail=count=0` at the edge; enqueue and dequeue suppressed that cycle; `fq_deq_cnt=0`.
- Storage contents are not cleared by reset/squash; validity comes only from `count`.

## Timing
- Reset values: `head=tail=count=0`; `fq_out_pkts[*].valid=0`, `fq_deq_cnt=0`, `fq_count=0`, `fq_in_ready=1`.
- Enqueue-to-output latency 1 cycle (no bypass of fetch to dispatch in the same cycle).
- `fq_out_pkts`, `fq_deq_cnt` combinational from state, `squash`, `dispatch_stall_mask`; `fq_in_ready`, `fq_count` from registers only.
- Simultaneous enqueue and dequeue of 3 each at `count=DEPTH-3`: legal, count unchanged.
- Empty: all outputs invalid, `fq_deq_cnt=0` regardless of stall mask.
- Full (`count=DEPTH`): `fq_in_ready=0`; dequeue proceeds normally.
- Wrap: group spanning `DEPTH-1`→0 stored and presented contiguously.
- Reset asserted mid-operation: state cleared asynchronously; outputs at reset values within the same cycle.

## Test plan
- Reset, then enqueue three valid packets PC 0x0/0x4/0x8, mask 3'b111 -> next cycle slots 2/1/0 show PC 0x0/0x4/0x8 valid, `fq_deq_cnt=0`, `fq_count=3`.
- Queue holds 0x0–0x14, mask 3'b000, slot 1 (0x4) `bp_pred_taken=1` -> `fq_deq_cnt=2`, next cycle slot 2 shows 0x8, `fq_count=4`.
- Mask 3'b010 (slot 1 stalled), no taken -> `fq_deq_cnt=1`; slot 0 not consumed though unstalled.
- Fill to 6 with DEPTH=8 -> `fq_in_ready=0`, offered group not written, `tail` unchanged; drain 1 -> `fq_in_ready=1` next cycle.
- Input valid pattern 3'b101 at `tail=7` -> entries at 7 and 0, `tail=1`, output order preserved across wrap.
- `squash` with `count=5`, simultaneous full enqueue and mask 3'b000 -> `fq_deq_cnt=0`, next cycle `count=0`, all outputs invalid, `fq_in_ready=1`.

Source files
------------

// File: rtl/fetch_dispatch_queue.sv
// Circular buffer between fetch and dispatch. It accepts up to three fetch packets per cycle
// and presents the three oldest to dispatch, with slot 2 holding the head.
package fetch_dispatch_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic        bp_pred_taken;
        logic [31:0] pc;
        logic [31:0] inst;
    } IF_ID_PACKET;

endpackage

module fetch_dispatch_queue
    import fetch_dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  IF_ID_PACKET [2:0] fq_in_pkts,
    output logic              fq_in_ready,
    input  logic [2:0]        dispatch_stall_mask,
    output IF_ID_PACKET [2:0] fq_out_pkts,
    output logic [1:0]        fq_deq_cnt,
    output logic [CNT_W-1:0]  fq_count
);

    IF_ID_PACKET      mem_q [DEPTH];
    IF_ID_PACKET      mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [2:0]       out_valid;
    logic [1:0]       deq_n;
    logic [1:0]       enq_n;
    logic             enq_en;
    logic             consume_ok;
    logic [PTR_W-1:0] rd_idx;
    logic [PTR_W-1:0] wr_idx;

    // Readiness ignores this cycle's dequeue so it never depends on dispatch's stall mask.
    assign fq_in_ready = (count_q <= CNT_W'(DEPTH - 3));
    assign fq_count    = count_q;

    always_comb begin
        fq_out_pkts = '0;
        out_valid   = '0;
        deq_n       = '0;
        consume_ok  = 1'b1;
        rd_idx      = head_q;
        for (int j = 0; j < 3; j++) begin
            rd_idx                 = head_q + PTR_W'(j);
            out_valid[j]           = !squash && (CNT_W'(j) < count_q);
            fq_out_pkts[2-j]       = mem_q[rd_idx];
            fq_out_pkts[2-j].valid = out_valid[j];
            // A taken branch is consumed itself but ends the group behind it.
            if (consume_ok && out_valid[j] && !dispatch_stall_mask[2-j]) begin
                deq_n = deq_n + 2'd1;
                if (mem_q[rd_idx].bp_pred_taken) begin
                    consume_ok = 1'b0;
                end
            end else begin
                consume_ok = 1'b0;
            end
        end
        fq_deq_cnt = deq_n;
    end

    always_comb begin
        mem_d  = mem_q;
        enq_n  = '0;
        wr_idx = tail_q;
        enq_en = fq_in_ready && !squash;
        for (int s = 2; s >= 0; s--) begin
            if (enq_en && fq_in_pkts[s].valid) begin
                mem_d[wr_idx] = fq_in_pkts[s];
                wr_idx        = wr_idx + PTR_W'(1);
                enq_n         = enq_n + 2'd1;
            end
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = wr_idx;
        count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never cleared; occupancy alone decides validity.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fetch_dispatch_queue.sv
// Self-checking bench for fetch_dispatch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_dispatch_queue;
    import fetch_dispatch_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    IF_ID_PACKET [2:0] fq_in_pkts;
    logic              fq_in_ready;
    logic [2:0]        dispatch_stall_mask;
    IF_ID_PACKET [2:0] fq_out_pkts;
    logic [1:0]        fq_deq_cnt;
    logic [CNT_W-1:0]  fq_count;

    fetch_dispatch_queue #(.DEPTH(DEPTH)) dut (
        .clock               (clock),
        .reset               (reset),
        .squash              (squash),
        .fq_in_pkts          (fq_in_pkts),
        .fq_in_ready         (fq_in_ready),
        .dispatch_stall_mask (dispatch_stall_mask),
        .fq_out_pkts         (fq_out_pkts),
        .fq_deq_cnt          (fq_deq_cnt),
        .fq_count            (fq_count)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    IF_ID_PACKET mq[$];
    IF_ID_PACKET exp_out[3];
    int          exp_deq;
    logic        exp_ready;
    int          exp_count;
    IF_ID_PACKET none = '0;

    function automatic IF_ID_PACKET mk(input logic [31:0] pc, input logic taken);
        IF_ID_PACKET p;
        p.valid         = 1'b1;
        p.bp_pred_taken = taken;
        p.pc            = pc;
        p.inst          = $urandom;
        return p;
    endfunction

    // Reference: the queue is an ordered list; dispatch takes oldest packets until a stall,
    // the end of the list, three packets, or just after a predicted-taken packet.
    task automatic model_eval();
        int n;
        exp_count = mq.size();
        exp_ready = (mq.size() <= DEPTH - 3);
        for (int k = 0; k < 3; k++) begin
            exp_out[k] = '0;
            if (!squash && (2 - k) < mq.size()) begin
                exp_out[k]       = mq[2-k];
                exp_out[k].valid = 1'b1;
            end
        end
        n = 0;
        if (!squash) begin
            while (n < 3 && n < mq.size() && !dispatch_stall_mask[2-n]) begin
                n++;
                if (mq[n-1].bp_pred_taken) break;
            end
        end
        exp_deq = n;
    endtask

    task automatic model_commit();
        if (squash) begin
            mq.delete();
        end else begin
            repeat (exp_deq) void'(mq.pop_front());
            if (exp_ready) begin
                for (int s = 2; s >= 0; s--)
                    if (fq_in_pkts[s].valid) mq.push_back(fq_in_pkts[s]);
            end
        end
    endtask

    task automatic applyStimulus(input IF_ID_PACKET p2, input IF_ID_PACKET p1, input IF_ID_PACKET p0,
                                 input logic [2:0] mask, input logic sq);
        fq_in_pkts[2]       = p2;
        fq_in_pkts[1]       = p1;
        fq_in_pkts[0]       = p0;
        dispatch_stall_mask = mask;
        squash              = sq;
        #3;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(mk(32'h40, 0), mk(32'h44, 0), mk(32'h48, 0), 3'b000, 1'b0);
        #4;
        n_cmp++; if (fq_count !== '0) begin n_bad++; $display("[TB] FAIL reset_count: got %0d want 0", fq_count); end
        n_cmp++; if (fq_in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 1", fq_in_ready); end
        n_cmp++; if (fq_deq_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_deq: got %0d want 0", fq_deq_cnt); end
        n_cmp++;
        if ({fq_out_pkts[2].valid, fq_out_pkts[1].valid, fq_out_pkts[0].valid} !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL reset_valid: got %b%b%b want 000", fq_out_pkts[2].valid, fq_out_pkts[1].valid, fq_out_pkts[0].valid);
        end
        applyStimulus(none, none, none, 3'b000, 1'b0);
        reset = 1'b0;
        mq.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        applyStimulus(mk(32'h0, 0), mk(32'h4, 0), mk(32'h8, 0), 3'b111, 1'b0);
        n_cmp++; if (fq_out_pkts[2].valid !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_no_bypass: got %b want 0", fq_out_pkts[2].valid); end
        tick();
        applyStimulus(none, none, none, 3'b111, 1'b0);
        n_cmp++; if ({fq_out_pkts[2].valid, fq_out_pkts[2].pc} !== {1'b1, 32'h0}) begin n_bad++; $display("[TB] FAIL basic_slot2: got %b/%h want 1/0", fq_out_pkts[2].valid, fq_out_pkts[2].pc); end
        n_cmp++; if ({fq_out_pkts[1].valid, fq_out_pkts[1].pc} !== {1'b1, 32'h4}) begin n_bad++; $display("[TB] FAIL basic_slot1: got %b/%h want 1/4", fq_out_pkts[1].valid, fq_out_pkts[1].pc); end
        n_cmp++; if ({fq_out_pkts[0].valid, fq_out_pkts[0].pc} !== {1'b1, 32'h8}) begin n_bad++; $display("[TB] FAIL basic_slot0: got %b/%h want 1/8", fq_out_pkts[0].valid, fq_out_pkts[0].pc); end
        n_cmp++; if (fq_deq_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL basic_deq: got %0d want 0", fq_deq_cnt); end
        n_cmp++; if (fq_count !== CNT_W'(3)) begin n_bad++; $display("[TB] FAIL basic_count: got %0d want 3", fq_count); end
        tick();
    endtask

    task automatic test_taken();
        applyStimulus(none, none, none, 3'b111, 1'b1);
        tick();
        applyStimulus(mk(32'h0, 0), mk(32'h4, 1), mk(32'h8, 0), 3'b111, 1'b0);
        tick();
        applyStimulus(mk(32'hc, 0), mk(32'h10, 0), mk(32'h14, 0), 3'b111, 1'b0);
        tick();
        applyStimulus(none, none, none, 3'b000, 1'b0);
        n_cmp++; if (fq_deq_cnt !== 2'd2) begin n_bad++; $display("[TB] FAIL taken_deq: got %0d want 2", fq_deq_cnt); end
        tick();
        applyStimulus(none, none, none, 3'b111, 1'b0);
        n_cmp++; if (fq_out_pkts[2].pc !== 32'h8) begin n_bad++; $display("[TB] FAIL taken_head: got %h want 8", fq_out_pkts[2].pc); end
        n_cmp++; if (fq_count !== CNT_W'(4)) begin n_bad++; $display("[TB] FAIL taken_count: got %0d want 4", fq_count); end
    endtask

    task automatic test_stall();
        applyStimulus(none, none, none, 3'b010, 1'b0);
        n_cmp++; if (fq_deq_cnt !== 2'd1) begin n_bad++; $display("[TB] FAIL stall_deq: got %0d want 1", fq_deq_cnt); end
        tick();
        applyStimulus(none, none, none, 3'b111, 1'b0);
        n_cmp++; if (fq_out_pkts[2].pc !== 32'hc) begin n_bad++; $display("[TB] FAIL stall_head: got %h want c", fq_out_pkts[2].pc); end
    endtask

    task automatic test_full();
        applyStimulus(mk(32'h18, 0), mk(32'h1c, 0), mk(32'h20, 0), 3'b111, 1'b0);
        tick();
        applyStimulus(mk(32'h900, 0), mk(32'h904, 0), mk(32'h908, 0), 3'b111, 1'b0);
        n_cmp++; if (fq_in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL full_ready: got %b want 0", fq_in_ready); end
        tick();
        applyStimulus(none, none, none, 3'b111, 1'b0);
        n_cmp++; if (fq_count !== CNT_W'(6)) begin n_bad++; $display("[TB] FAIL full_count: got %0d want 6", fq_count); end
        applyStimulus(none, none, none, 3'b011, 1'b0);
        n_cmp++; if (fq_deq_cnt !== 2'd1) begin n_bad++; $display("[TB] FAIL full_drain: got %0d want 1", fq_deq_cnt); end
        tick();
        applyStimulus(none, none, none, 3'b111, 1'b0);
        n_cmp++; if (fq_in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL full_reopen: got %b want 1", fq_in_ready); end
        n_cmp++; if (fq_count !== CNT_W'(5)) begin n_bad++; $display("[TB] FAIL full_count5: got %0d want 5", fq_count); end
        // Entries after the dropped group must still be the accepted ones.
        applyStimulus(none, none, none, 3'b000, 1'b0);
        tick();
        applyStimulus(none, none, none, 3'b111, 1'b0);
        n_cmp++; if (fq_out_pkts[2].pc !== 32'h1c) begin n_bad++; $display("[TB] FAIL full_nodrop: got %h want 1c", fq_out_pkts[2].pc); end
    endtask

    task automatic test_wrap();
        applyStimulus(none, none, none, 3'b111, 1'b1);
        tick();
        applyStimulus(mk(32'h100, 0), mk(32'h104, 0), mk(32'h108, 0), 3'b111, 1'b0);
        tick();
        applyStimulus(mk(32'h200, 0), mk(32'h204, 0), mk(32'h208, 0), 3'b000, 1'b0);
        n_cmp++; if (fq_deq_cnt !== 2'd3) begin n_bad++; $display("[TB] FAIL wrap_deq3: got %0d want 3", fq_deq_cnt); end
        tick();
        applyStimulus(mk(32'h300, 0), none, none, 3'b000, 1'b0);
        tick();
        applyStimulus(mk(32'h400, 0), none, mk(32'h408, 0), 3'b111, 1'b0);
        tick();
        applyStimulus(none, none, none, 3'b111, 1'b0);
        n_cmp++;
        if ({fq_out_pkts[2].pc, fq_out_pkts[1].pc, fq_out_pkts[0].pc} !== {32'h300, 32'h400, 32'h408}) begin
            n_bad++;
            $display("[TB] FAIL wrap_order: got %h %h %h want 300 400 408", fq_out_pkts[2].pc, fq_out_pkts[1].pc, fq_out_pkts[0].pc);
        end
        n_cmp++; if (fq_count !== CNT_W'(3)) begin n_bad++; $display("[TB] FAIL wrap_count: got %0d want 3", fq_count); end
        applyStimulus(mk(32'h500, 0), mk(32'h504, 0), mk(32'h508, 0), 3'b000, 1'b0);
        tick();
        applyStimulus(none, none, none, 3'b111, 1'b0);
        n_cmp++; if (fq_out_pkts[2].pc !== 32'h500) begin n_bad++; $display("[TB] FAIL wrap_tail: got %h want 500", fq_out_pkts[2].pc); end
    endtask

    task automatic test_squash();
        applyStimulus(none, none, none, 3'b111, 1'b1);
        tick();
        applyStimulus(mk(32'h600, 0), mk(32'h604, 0), mk(32'h608, 0), 3'b111, 1'b0);
        tick();
        applyStimulus(mk(32'h60c, 0), mk(32'h610, 0), none, 3'b111, 1'b0);
        tick();
        applyStimulus(mk(32'h700, 0), mk(32'h704, 0), mk(32'h708, 0), 3'b000, 1'b1);
        n_cmp++; if (fq_deq_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL squash_deq: got %0d want 0", fq_deq_cnt); end
        n_cmp++;
        if ({fq_out_pkts[2].valid, fq_out_pkts[1].valid, fq_out_pkts[0].valid} !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL squash_valid: got %b%b%b want 000", fq_out_pkts[2].valid, fq_out_pkts[1].valid, fq_out_pkts[0].valid);
        end
        tick();
        applyStimulus(none, none, none, 3'b000, 1'b0);
        n_cmp++; if (fq_count !== '0) begin n_bad++; $display("[TB] FAIL squash_count: got %0d want 0", fq_count); end
        n_cmp++; if (fq_in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL squash_ready: got %b want 1", fq_in_ready); end
        n_cmp++; if (fq_out_pkts[2].valid !== 1'b0) begin n_bad++; $display("[TB] FAIL squash_empty: got %b want 0", fq_out_pkts[2].valid); end
    endtask

    task automatic test_random();
        IF_ID_PACKET p[3];
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 3; s++) begin
                p[s] = mk($urandom, ($urandom_range(3) == 0));
                p[s].valid = ($urandom_range(3) != 0);
            end
            applyStimulus(p[2], p[1], p[0], 3'($urandom), ($urandom_range(24) == 0));
            n_cmp++; if (fq_count !== CNT_W'(exp_count)) begin n_bad++; $display("[TB] FAIL rnd_count c=%0d: got %0d want %0d", c, fq_count, exp_count); end
            n_cmp++; if (fq_in_ready !== exp_ready) begin n_bad++; $display("[TB] FAIL rnd_ready c=%0d: got %b want %b", c, fq_in_ready, exp_ready); end
            n_cmp++; if (fq_deq_cnt !== 2'(exp_deq)) begin n_bad++; $display("[TB] FAIL rnd_deq c=%0d: got %0d want %0d", c, fq_deq_cnt, exp_deq); end
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (exp_out[k].valid ? (fq_out_pkts[k] !== exp_out[k]) : (fq_out_pkts[k].valid !== 1'b0)) begin
                    n_bad++;
                    $display("[TB] FAIL rnd_slot%0d c=%0d: got %h want %h", k, c, fq_out_pkts[k], exp_out[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(none, none, none, 3'b111, 1'b1);
        tick();
        applyStimulus(mk(32'h800, 0), mk(32'h804, 0), mk(32'h808, 0), 3'b111, 1'b0);
        tick();
        applyStimulus(none, none, none, 3'b000, 1'b0);
        reset = 1'b1;
        #1;
        n_cmp++; if (fq_count !== '0) begin n_bad++; $display("[TB] FAIL async_count: got %0d want 0", fq_count); end
        n_cmp++; if (fq_deq_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL async_deq: got %0d want 0", fq_deq_cnt); end
        n_cmp++; if (fq_out_pkts[2].valid !== 1'b0) begin n_bad++; $display("[TB] FAIL async_valid: got %b want 0", fq_out_pkts[2].valid); end
        reset = 1'b0;
        mq.delete();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset               = 1'b1;
        squash              = 1'b0;
        fq_in_pkts          = '0;
        dispatch_stall_mask = '0;
        #1;
        test_reset();
        test_basic();
        test_taken();
        test_stall();
        test_full();
        test_wrap();
        test_squash();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
